// File: rtl/addsub_seq_nbit_if.sv
// Handshake and data bundle for the multi-cycle add/subtract unit.
// The producer/consumer side uses master, the arithmetic block uses slave.
interface addsub_seq_nbit_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             v_flag;
    logic             z_flag;
    logic             n_flag;

    modport master (
        output in_valid, A, B, sub, signed_mode, out_ready,
        input  in_ready, out_valid, Sum, Cout, v_flag, z_flag, n_flag
    );

    modport slave (
        input  in_valid, A, B, sub, signed_mode, out_ready,
        output in_ready, out_valid, Sum, Cout, v_flag, z_flag, n_flag
    );
endinterface

// File: rtl/addsub_seq_nbit.sv
// Multi-cycle WIDTH-bit add/subtract: CHUNK bits per cycle through a registered
// inter-chunk carry, with carry, overflow, zero and negative flags.
module addsub_seq_nbit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    addsub_seq_nbit_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NCHUNK - 1);

    generate
        if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("addsub_seq_nbit: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             in_ready_nxt_s;
    logic             out_valid_nxt_s;
    logic             accept_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_eff_r;
    logic             sub_r;
    logic             smode_r;
    logic             carry_r;
    logic [KW-1:0]    k_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             v_r;
    logic             z_r;
    logic             n_r;
    logic [CHUNK:0]   chunk_sum_s;
    logic [WIDTH-1:0] sum_nxt_s;
    logic             v_nxt_s;

    assign accept_s = bus.in_valid & in_ready_r & (state_r == ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_RUN;
                else          state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (k_r == LAST_K) state_nxt_s = ST_DONE;
                else               state_nxt_s = ST_RUN;
            end
            ST_DONE: begin
                if (bus.out_ready) state_nxt_s = ST_IDLE;
                else               state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake outputs follow the state being entered so they leave flops
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE: in_ready_nxt_s  = 1'b1;
            ST_DONE: out_valid_nxt_s = 1'b1;
            default: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Handshake output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    // One chunk of the ripple plus the merged result and overflow it would produce
    always_comb begin
        chunk_sum_s = {1'b0, a_r[k_r*CHUNK +: CHUNK]}
                    + {1'b0, b_eff_r[k_r*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, carry_r};
        sum_nxt_s = sum_r;
        sum_nxt_s[k_r*CHUNK +: CHUNK] = chunk_sum_s[CHUNK-1:0];
        if (smode_r) begin
            v_nxt_s = (a_r[WIDTH-1] == b_eff_r[WIDTH-1]) & (sum_nxt_s[WIDTH-1] != a_r[WIDTH-1]);
        end else if (sub_r) begin
            v_nxt_s = ~chunk_sum_s[CHUNK];
        end else begin
            v_nxt_s = chunk_sum_s[CHUNK];
        end
    end

    // Operand capture, chunk sequencing and result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_eff_r <= {WIDTH{1'b0}};
            sub_r   <= 1'b0;
            smode_r <= 1'b0;
            carry_r <= 1'b0;
            k_r     <= {KW{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            v_r     <= 1'b0;
            z_r     <= 1'b0;
            n_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r     <= bus.A;
                        b_eff_r <= bus.B ^ {WIDTH{bus.sub}};
                        sub_r   <= bus.sub;
                        smode_r <= bus.signed_mode;
                        carry_r <= bus.sub;
                        k_r     <= {KW{1'b0}};
                    end
                end
                ST_RUN: begin
                    sum_r   <= sum_nxt_s;
                    carry_r <= chunk_sum_s[CHUNK];
                    k_r     <= k_r + KW'(1);
                    if (k_r == LAST_K) begin
                        cout_r <= chunk_sum_s[CHUNK];
                        v_r    <= v_nxt_s;
                        z_r    <= (sum_nxt_s == {WIDTH{1'b0}});
                        n_r    <= sum_nxt_s[WIDTH-1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.Sum       = sum_r;
    assign bus.Cout      = cout_r;
    assign bus.v_flag    = v_r;
    assign bus.z_flag    = z_r;
    assign bus.n_flag    = n_r;
endmodule

// File: tb/tb_addsub_seq_nbit.sv
// Bench for addsub_seq_nbit at 8/8, 16/4 and 32/8: directed table, backpressure,
// mid-run reset and random operations against an arithmetic reference model.
module tb_addsub_seq_nbit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [31:0] a_d [3];
    logic [31:0] b_d [3];
    logic        sub_d [3];
    logic        sm_d [3];
    logic        iv_d [3];
    logic        ordy_d [3];
    logic [31:0] sum_o [3];
    logic        ir_o [3];
    logic        ov_o [3];
    logic        c_o [3];
    logic        v_o [3];
    logic        z_o [3];
    logic        n_o [3];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        sm;
        logic [31:0] sum;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } vec_t;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int W = (g == 0) ? 8 : ((g == 1) ? 16 : 32);
            localparam int C = (g == 1) ? 4 : 8;
            addsub_seq_nbit_if #(.WIDTH(W)) bus ();
            assign bus.in_valid    = iv_d[g];
            assign bus.A           = a_d[g][W-1:0];
            assign bus.B           = b_d[g][W-1:0];
            assign bus.sub         = sub_d[g];
            assign bus.signed_mode = sm_d[g];
            assign bus.out_ready   = ordy_d[g];
            assign ir_o[g]  = bus.in_ready;
            assign ov_o[g]  = bus.out_valid;
            assign sum_o[g] = 32'(bus.Sum);
            assign c_o[g]   = bus.Cout;
            assign v_o[g]   = bus.v_flag;
            assign z_o[g]   = bus.z_flag;
            assign n_o[g]   = bus.n_flag;
            addsub_seq_nbit #(.WIDTH(W), .CHUNK(C)) dut (
                .clk   (clk),
                .rst_n (rst_n),
                .bus   (bus)
            );
        end
    endgenerate

    function automatic int wid_of(input int id);
        return (id == 0) ? 8 : ((id == 1) ? 16 : 32);
    endfunction

    function automatic int chk_of(input int id);
        return (id == 1) ? 4 : 8;
    endfunction

    // Reference: whole-word integer arithmetic and range tests
    function automatic void ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                      input logic s, input logic m, output logic [31:0] rs,
                                      output logic rc, output logic rv, output logic rz, output logic rn);
        longint mask, ua, ub, full, smax, smin, sa, sb, r;
        mask = (64'sd1 <<< w) - 64'sd1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        full = s ? (ua - ub) : (ua + ub);
        rc   = s ? (ua >= ub) : (full > mask);
        rs   = 32'(full & mask);
        smax = (64'sd1 <<< (w - 1)) - 64'sd1;
        smin = -(64'sd1 <<< (w - 1));
        sa   = (ua > smax) ? (ua - mask - 64'sd1) : ua;
        sb   = (ub > smax) ? (ub - mask - 64'sd1) : ub;
        r    = s ? (sa - sb) : (sa + sb);
        rv   = m ? ((r > smax) || (r < smin)) : (s ? !rc : rc);
        rz   = (rs == 32'd0);
        rn   = rs[w-1];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic m, input int hold,
                         input logic [31:0] es, input logic ec, input logic ev,
                         input logic ez, input logic en, input string tag);
        int n;
        n = 0;
        while (ir_o[id] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".ready"}, 32'(ir_o[id]), 32'd1);
        a_d[id] = a; b_d[id] = b; sub_d[id] = s; sm_d[id] = m; iv_d[id] = 1'b1;
        @(posedge clk); #1;
        iv_d[id] = 1'b0;
        a_d[id] = $urandom; b_d[id] = $urandom;
        sub_d[id] = 1'($urandom); sm_d[id] = 1'($urandom);
        check({tag, ".busy"}, 32'(ir_o[id]), 32'd0);
        n = 0;
        while (ov_o[id] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(wid_of(id) / chk_of(id)));
        for (int h = 0; h < hold; h++) begin
            a_d[id] = $urandom; b_d[id] = $urandom; iv_d[id] = 1'($urandom);
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 32'(ov_o[id]), 32'd1);
            check({tag, ".hold_ready"}, 32'(ir_o[id]), 32'd0);
            check({tag, ".hold_sum"}, sum_o[id], es);
        end
        iv_d[id] = 1'b0;
        check({tag, ".sum"}, sum_o[id], es);
        check({tag, ".cout"}, 32'(c_o[id]), 32'(ec));
        check({tag, ".v"}, 32'(v_o[id]), 32'(ev));
        check({tag, ".z"}, 32'(z_o[id]), 32'(ez));
        check({tag, ".n"}, 32'(n_o[id]), 32'(en));
        ordy_d[id] = 1'b1;
        @(posedge clk); #1;
        ordy_d[id] = 1'b0;
        check({tag, ".pop_valid"}, 32'(ov_o[id]), 32'd0);
        check({tag, ".pop_ready"}, 32'(ir_o[id]), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[$];
        logic [31:0] es, ra, rb;
        logic        ec, ev, ez, en, rsub, rsm;
        int          rid;

        for (int i = 0; i < 3; i++) begin
            a_d[i] = 32'd0; b_d[i] = 32'd0; sub_d[i] = 1'b0;
            sm_d[i] = 1'b0; iv_d[i] = 1'b0; ordy_d[i] = 1'b0;
        end

        vt.push_back('{1, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0});
        vt.push_back('{1, 32'h00007FFF, 32'h00000001, 1'b0, 1'b1, 32'h00008000, 1'b0, 1'b1, 1'b0, 1'b1});
        vt.push_back('{1, 32'h00000003, 32'h00000005, 1'b1, 1'b0, 32'h0000FFFE, 1'b0, 1'b1, 1'b0, 1'b1});
        vt.push_back('{1, 32'h00000005, 32'h00000003, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1, 32'h00008000, 32'h00000001, 1'b1, 1'b1, 32'h00007FFF, 1'b1, 1'b1, 1'b0, 1'b0});
        vt.push_back('{1, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0});
        vt.push_back('{0, 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0});
        vt.push_back('{0, 32'h0000007F, 32'h00000001, 1'b0, 1'b1, 32'h00000080, 1'b0, 1'b1, 1'b0, 1'b1});
        vt.push_back('{0, 32'h00000003, 32'h00000005, 1'b1, 1'b0, 32'h000000FE, 1'b0, 1'b1, 1'b0, 1'b1});
        vt.push_back('{0, 32'h00000080, 32'h00000001, 1'b1, 1'b1, 32'h0000007F, 1'b1, 1'b1, 1'b0, 1'b0});
        vt.push_back('{2, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0});
        vt.push_back('{2, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1});
        vt.push_back('{2, 32'h00000003, 32'h00000005, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b1});
        vt.push_back('{2, 32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0});

        // reset state
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst%0d.valid", i), 32'(ov_o[i]), 32'd0);
            check($sformatf("rst%0d.ready", i), 32'(ir_o[i]), 32'd0);
            check($sformatf("rst%0d.sum", i), sum_o[i], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rel%0d.ready", i), 32'(ir_o[i]), 32'd1);
        end

        for (int i = 0; i < vt.size(); i++) begin
            do_op(vt[i].id, vt[i].a, vt[i].b, vt[i].sub, vt[i].sm, 0,
                  vt[i].sum, vt[i].c, vt[i].v, vt[i].z, vt[i].n, $sformatf("vec%0d", i));
        end

        // backpressure, then an independent op right behind it
        do_op(1, 32'h1234, 32'h1111, 1'b0, 1'b0, 5, 32'h2345, 1'b0, 1'b0, 1'b0, 1'b0, "bp");
        do_op(1, 32'h1000, 32'h2000, 1'b1, 1'b1, 0, 32'hF000, 1'b0, 1'b0, 1'b0, 1'b1, "bp_next");

        // asynchronous reset with k = 2
        a_d[1] = 32'h1234; b_d[1] = 32'h4321; sub_d[1] = 1'b0; sm_d[1] = 1'b0; iv_d[1] = 1'b1;
        @(posedge clk); #1;
        iv_d[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrun.valid", 32'(ov_o[1]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst.sum", sum_o[1], 32'd0);
        check("midrst.cout", 32'(c_o[1]), 32'd0);
        check("midrst.v", 32'(v_o[1]), 32'd0);
        check("midrst.n", 32'(n_o[1]), 32'd0);
        check("midrst.valid", 32'(ov_o[1]), 32'd0);
        check("midrst.ready", 32'(ir_o[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrel.ready", 32'(ir_o[1]), 32'd1);
        do_op(1, 32'h8001, 32'h8001, 1'b0, 1'b1, 0, 32'h0002, 1'b1, 1'b1, 1'b0, 1'b0, "after_rst");

        for (int i = 0; i < 1000; i++) begin
            rid  = i % 3;
            ra   = $urandom;
            rb   = $urandom;
            rsub = 1'($urandom);
            rsm  = 1'($urandom);
            ref_model(wid_of(rid), ra, rb, rsub, rsm, es, ec, ev, ez, en);
            do_op(rid, ra, rb, rsub, rsm, $urandom_range(0, 2), es, ec, ev, ez, en,
                  $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/addsub_seq_nbit.md
Name: addsub_seq_nbit

Overview:
- Parametrised, multi-cycle successor to the team's 8-bit ripple add/subtract unit.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock using a registered inter-chunk carry, trading latency for a short carry chain at large WIDTH.
- Produces sum, carry-out, a mode-dependent overflow flag (same semantics as the existing 8-bit unit), plus zero and negative flags.
- Sits behind valid/ready handshakes inside the ALU datapath.

Parameters:
- WIDTH, 16: operand/result width in bits; must be ≥ 2.
- CHUNK, 4: bits processed per RUN cycle; WIDTH must be an integer multiple of CHUNK (elaboration-time check).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode are valid this cycle.
- in_ready  output  1  block can accept an operation.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- sub  input  1  0 = A+B; 1 = A+~B+1 (A−B).
- signed_mode  input  1  1 = signed overflow rule; 0 = unsigned rule.
- out_valid  output  1  result fields valid.
- out_ready  input  1  consumer takes the result.
- Sum  output  WIDTH  result.
- Cout  output  1  raw carry out of the MSB. For sub, 1 means no borrow.
- v_flag  output  1  overflow flag.
- z_flag  output  1  Sum == 0.
- n_flag  output  1  Sum[WIDTH-1].

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset (async assert, any state): state goes to IDLE. Sum, Cout, v_flag, z_flag, n_flag and out_valid all clear to 0; chunk counter and carry register clear. in_ready = 1 from the first clk edge after deassertion.
- State IDLE: in_ready = 1, out_valid = 0. On in_valid & in_ready:
  - latch A, sub, signed_mode, and B_eff = B ^ {WIDTH{sub}};
  - load the carry register with sub;
  - set chunk index k = 0; go to RUN.
- State RUN: in_ready = 0. Each cycle, add chunk k of A, chunk k of B_eff and the carry register.
  - Write the CHUNK-bit result into Sum bits [k*CHUNK +: CHUNK] of the internal result register.
  - Update the carry register with the chunk carry-out.
  - k increments. On the last chunk (k = WIDTH/CHUNK − 1), compute flags and go to DONE.
  - Latency: acceptance edge + WIDTH/CHUNK RUN cycles. out_valid rises on the edge that ends the last RUN cycle. With CHUNK = WIDTH, RUN lasts 1 cycle.
- Flags (computed from the final carry and the latched operands):
  - Cout = final carry.
  - signed_mode = 1: v_flag = (A[MSB] == B_eff[MSB]) & (Sum[MSB] != A[MSB]), for both add and sub.
  - signed_mode = 0: v_flag = Cout for add, ~Cout for sub (borrow).
  - z_flag = (Sum == 0). n_flag = Sum[MSB].
- State DONE: out_valid = 1, in_ready = 0.
  - Sum and all flags are held stable while out_valid & ~out_ready.
  - On out_valid & out_ready, go to IDLE; out_valid drops next cycle and in_ready rises next cycle. No same-cycle accept on pop.
  - Result registers keep their last values in IDLE (not cleared).
- Input stability: A, B, sub and signed_mode changes after acceptance have no effect. in_valid while in_ready = 0 is ignored and must not be queued.
- Internal Sum bits are only visible once out_valid = 1. Partial results may appear on Sum during RUN but carry no meaning.

Test Plan:
1. WIDTH=16, CHUNK=4. Unsigned add A=0xFFFF, B=0x0001 → after 4 RUN cycles: Sum=0x0000, Cout=1, v_flag=1, z_flag=1, n_flag=0. out_valid rises exactly 4 cycles after the accept edge.
2. Signed add A=0x7FFF, B=0x0001, signed_mode=1 → Sum=0x8000, Cout=0, v_flag=1, n_flag=1, z_flag=0.
3. Unsigned sub A=0x0003, B=0x0005 → Sum=0xFFFE, Cout=0, v_flag=1 (borrow), n_flag=1. Then A=0x0005, B=0x0003 → Sum=0x0002, Cout=1, v_flag=0.
4. Signed sub A=0x8000, B=0x0001, signed_mode=1 → Sum=0x7FFF, Cout=1, v_flag=1, n_flag=0.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling A/B and pulsing in_valid → outputs unchanged, in_ready=0, no new op starts. Raise out_ready → in_ready=1 next cycle. Next op is accepted and produces a correct independent result.
6. Reset/param sweep: assert rst_n=0 during RUN (k=2) → all outputs 0 immediately, in_ready=1 after release, next op correct. Repeat scenarios 1–4 at WIDTH=8/CHUNK=8 (1-cycle RUN) and WIDTH=32/CHUNK=8 against a reference model over 1000 random operand/mode sets.
